// File: rtl/state_inv_isomorphic_mapper_pkg.sv
// Shared constants, FSM encoding and parameter legality check for the
// inverse isomorphic mapper (composite field -> GF(2^8)).
package state_inv_isomorphic_mapper_pkg;

  localparam int BYTE_W    = 8;
  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = BYTE_W * BLK_BYTES;

  // Bit p set <=> p bytes/cycle is a legal mapping width (1,2,4,8,16).
  localparam logic [BLK_BYTES:0] LEGAL_P_MASK = 17'h10116;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic bit p_is_legal(int p);
    logic [BLK_BYTES:0] m;
    if (p < 1 || p > BLK_BYTES) return 1'b0;
    m = LEGAL_P_MASK >> p;
    return m[0];
  endfunction

endpackage

// File: rtl/state_inv_isomorphic_mapper_byte_map.sv
// Per-byte inverse isomorphic map: q = M^-1 * delta over GF(2).
module byte_inv_isomorphic_mapping
  import state_inv_isomorphic_mapper_pkg::*;
(
  input  logic [BYTE_W-1:0] delta,
  output logic [BYTE_W-1:0] q
);

  // Rows of the inverse matrix, derived from the forward map columns.
  always_comb begin
    q[7] = delta[7] ^ delta[6] ^ delta[5] ^ delta[1];
    q[6] = delta[6] ^ delta[2];
    q[5] = delta[6] ^ delta[5] ^ delta[1];
    q[4] = delta[6] ^ delta[5] ^ delta[4] ^ delta[2] ^ delta[1];
    q[3] = delta[5] ^ delta[4] ^ delta[3] ^ delta[2] ^ delta[1];
    q[2] = delta[7] ^ delta[4] ^ delta[3] ^ delta[2] ^ delta[1];
    q[1] = delta[5] ^ delta[4];
    q[0] = delta[6] ^ delta[5] ^ delta[4] ^ delta[2] ^ delta[0];
  end

endmodule

// File: rtl/state_inv_isomorphic_mapper.sv
// Block-level inverse isomorphic mapper: captures a 16-byte block, maps
// NB_BYTES_PER_CYCLE bytes per cycle (byte 0 first), then holds the result
// until downstream takes it.
module state_inv_isomorphic_mapper
  import state_inv_isomorphic_mapper_pkg::*;
#(
  parameter int NB_DATA            = 128,
  parameter int NB_BYTES_PER_CYCLE = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready
);

  localparam int P      = NB_BYTES_PER_CYCLE;
  localparam int N      = BLK_BYTES / P;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LANE_W = P * BYTE_W;

  if (NB_DATA != BLK_W) begin : g_bad_width
    $error("state_inv_isomorphic_mapper: NB_DATA must be 128");
  end
  if (!p_is_legal(P)) begin : g_bad_p
    $error("state_inv_isomorphic_mapper: NB_BYTES_PER_CYCLE must be 1,2,4,8 or 16");
  end

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [NB_DATA-1:0]       cap_q, odata_q;
  logic [P-1:0][BYTE_W-1:0] lane_in, lane_out;
  logic                     last;
  int unsigned              base;

  assign last    = (cnt == CNT_W'(N - 1));
  assign base    = int'(cnt) * LANE_W;
  assign lane_in = cap_q[base +: LANE_W];

  for (genvar l = 0; l < P; l++) begin : g_lane
    byte_inv_isomorphic_mapping u_map (
      .delta (lane_in[l]),
      .q     (lane_out[l])
    );
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state: accept in IDLE, N mapping cycles in PROC, handshake out of HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_valid) state_nxt = ST_PROC;
      ST_PROC: if (last)    state_nxt = ST_HOLD;
      ST_HOLD: if (i_ready) state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, then write P mapped bytes per PROC cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt     <= '0;
      cap_q   <= '0;
      odata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_valid) begin
          cap_q <= i_data;
          cnt   <= '0;
        end
        ST_PROC: begin
          odata_q[base +: LANE_W] <= lane_out;
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_HOLD);
  assign o_data  = odata_q;

endmodule

// File: tb/tb_state_inv_isomorphic_mapper.sv
// Bench for state_inv_isomorphic_mapper: one instance per legal P, directed
// steps with a scoreboard queue and a golden forward map on the outputs.
module tb_state_inv_isomorphic_mapper;

  localparam int NI = 5;

  typedef struct {
    int           k;
    logic [127:0] din;
    bit           exact;
    logic [127:0] dout;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] idat [NI];
  logic [127:0] odat [NI];
  logic         ivld [NI];
  logic         irdy [NI];
  logic         ordy [NI];
  logic         ovld [NI];

  sb_t q[$];
  int  nchk;
  int  nerr;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    state_inv_isomorphic_mapper #(
      .NB_DATA            (128),
      .NB_BYTES_PER_CYCLE (1 << g)
    ) u_dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_data    (idat[g]),
      .i_valid   (ivld[g]),
      .o_ready   (ordy[g]),
      .o_data    (odat[g]),
      .o_valid   (ovld[g]),
      .i_ready   (irdy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] fwd(logic [7:0] x);
    logic [7:0] d;
    d[7] = x[7] ^ x[5];
    d[6] = x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    d[5] = x[7] ^ x[5] ^ x[3] ^ x[2];
    d[4] = x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1];
    d[3] = x[7] ^ x[6] ^ x[2] ^ x[1];
    d[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    d[1] = x[6] ^ x[4] ^ x[1];
    d[0] = x[6] ^ x[1] ^ x[0];
    return d;
  endfunction

  function automatic logic [127:0] fwd_blk(logic [127:0] b);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = fwd(b[j*8 +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Pop the oldest expectation and compare it with what instance k presents.
  task automatic pop_check(input int k, input string tag);
    sb_t e;
    if (q.size() == 0) begin
      nchk++;
      nerr++;
      $error("FAIL %s unexpected output observed=%h expected=none", tag, odat[k]);
    end else begin
      e = q.pop_front();
      chk({tag, " inst"}, 128'(k), 128'(e.k));
      chk({tag, " map"}, fwd_blk(odat[k]), e.din);
      if (e.exact) chk({tag, " data"}, odat[k], e.dout);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input int k, input logic [127:0] d, input bit exact,
                      input logic [127:0] dexp, input string tag);
    int n;
    sb_t e;
    n = 0;
    while (!ordy[k] && n < 64) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 128'(ordy[k]), 128'd1);
    idat[k] = d;
    ivld[k] = 1'b1;
    e.k = k; e.din = d; e.exact = exact; e.dout = dexp;
    q.push_back(e);
    @(negedge clk);
    ivld[k] = 1'b0;
    chk({tag, " busy"}, 128'(ordy[k]), 128'd0);
    chk({tag, " nvld"}, 128'(ovld[k]), 128'd0);
  endtask

  // Counts negedges until o_valid, checks latency, result and the handshake.
  task automatic recv(input int k, input int lat, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!ovld[k] && n < 64);
    chk({tag, " latency"}, 128'(n), 128'(lat));
    pop_check(k, tag);
    @(negedge clk);
    chk({tag, " idle rdy"}, 128'(ordy[k]), 128'd1);
    chk({tag, " idle vld"}, 128'(ovld[k]), 128'd0);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] snap;
    sb_t          e;
    int           cyc, nacc, nout, lastacc;

    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      idat[k] = '0; ivld[k] = 1'b0; irdy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset ready", 128'(ordy[k]), 128'd1);
      chk("reset valid", 128'(ovld[k]), 128'd0);
      chk("reset data", odat[k], 128'd0);
    end
    rst_n = 1'b1;

    // Directed single bytes; first acceptance on the first edge after reset.
    send(2, 128'h01, 1'b1, 128'h01, "byte01");
    recv(2, 4, "byte01");
    send(2, 128'hFC, 1'b1, 128'h80, "byteFC");
    recv(2, 4, "byteFC");
    send(2, 128'h5F, 1'b1, 128'h02, "byte5F");
    recv(2, 4, "byte5F");

    // All 256 byte values through every legal P.
    for (int k = 0; k < NI; k++) begin
      for (int b = 0; b < 16; b++) begin
        for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'(b * 16 + j);
        send(k, d, 1'b0, '0, "exhaustive");
        recv(k, 16 >> k, "exhaustive");
      end
    end

    // Backpressure in HOLD with i_valid held high and i_data churning.
    irdy[2] = 1'b0;
    d = 128'h0123456789abcdeffedcba9876543210;
    idat[2] = d; ivld[2] = 1'b1;
    e.k = 2; e.din = d; e.exact = 1'b0; e.dout = '0;
    q.push_back(e);
    repeat (4) begin
      @(negedge clk);
      idat[2] = rnd128();
      chk("blocked proc rdy", 128'(ordy[2]), 128'd0);
      chk("blocked proc vld", 128'(ovld[2]), 128'd0);
    end
    @(negedge clk);
    chk("bp valid rise", 128'(ovld[2]), 128'd1);
    pop_check(2, "bp first");
    snap = odat[2];
    repeat (10) begin
      @(negedge clk);
      idat[2] = rnd128();
      chk("bp hold vld", 128'(ovld[2]), 128'd1);
      chk("bp hold data", odat[2], snap);
      chk("bp hold rdy", 128'(ordy[2]), 128'd0);
    end
    d = rnd128();
    idat[2] = d;
    e.din = d;
    q.push_back(e);
    irdy[2] = 1'b1;
    @(negedge clk);
    chk("bp release rdy", 128'(ordy[2]), 128'd1);
    chk("bp release vld", 128'(ovld[2]), 128'd0);
    @(negedge clk);
    ivld[2] = 1'b0;
    chk("bp second busy", 128'(ordy[2]), 128'd0);
    recv(2, 4, "bp second");

    // Reset during PROC discards the block.
    send(2, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0, '0, "rst blk");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst vld", 128'(ovld[2]), 128'd0);
    chk("rst data", odat[2], 128'd0);
    chk("rst rdy", 128'(ordy[2]), 128'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 128'h5F, 1'b1, 128'h02, "post rst");
    recv(2, 4, "post rst");

    // Back-to-back with i_valid and i_ready tied high.
    cyc = 0; nacc = 0; nout = 0; lastacc = 0;
    irdy[2] = 1'b1;
    while (nout < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (nacc == 6) ivld[2] = 1'b0;
      if (ovld[2]) begin
        pop_check(2, "b2b");
        nout++;
      end
      if (ordy[2] && nacc < 6) begin
        if (nacc > 0) chk("b2b period", 128'(cyc - lastacc), 128'd6);
        d = rnd128();
        idat[2] = d; ivld[2] = 1'b1;
        e.k = 2; e.din = d; e.exact = 1'b0; e.dout = '0;
        q.push_back(e);
        lastacc = cyc;
        nacc++;
      end
    end
    chk("b2b outputs", 128'(nout), 128'd6);
    ivld[2] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
